// File: rtl/trig_stream_pkg.sv
// Shared constants, FSM state type and record-to-word packing for trig_stream.
// The TRL state exists only when TRIG_STREAM_TRAILER_EN is defined.
package trig_stream_pkg;

   localparam int TRIG_W = 18;
   localparam int TIME_W = 36;
   localparam int WORD_W = 16;
   localparam int REC_W  = 55;

   // Record layout {ovf, trignum, timenum} and the word split points
   localparam int REC_OVF_BIT = 54;
   localparam int REC_TN_LSB  = 36;
   localparam int W0_TN_LSB   = 6;
   localparam int W1_TM_LSB   = 26;
   localparam int W2_TM_LSB   = 10;

   localparam logic [3:0] TAG_DEFAULT = 4'hF;

`ifdef TRIG_STREAM_TRAILER_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_W0 = 3'd2, ST_W1 = 3'd3,
      ST_W2 = 3'd4, ST_W3 = 3'd5, ST_TRL = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_W0 = 3'd2, ST_W1 = 3'd3,
      ST_W2 = 3'd4, ST_W3 = 3'd5
   } state_t;
`endif

   // Returns {W0, W1, W2, W3} for one record.
   function automatic logic [4*WORD_W-1:0] rec_words(
      input logic [REC_W-1:0] rec,
      input logic [3:0]       tag,
      input logic [4:0]       chan
   );
      logic [TRIG_W-1:0] tn;
      logic [TIME_W-1:0] tm;
      logic              ovf;
      tn  = rec[REC_TN_LSB +: TRIG_W];
      tm  = rec[TIME_W-1:0];
      ovf = rec[REC_OVF_BIT];
      return {tag, tn[TRIG_W-1:W0_TN_LSB],
              tn[W0_TN_LSB-1:0], tm[TIME_W-1:W1_TM_LSB],
              tm[W1_TM_LSB-1:W2_TM_LSB],
              tm[W2_TM_LSB-1:0], ovf, chan};
   endfunction

endpackage

// File: rtl/trig_rec_fifo.sv
// Single-clock record FIFO with occupancy count; head entry visible on rd_data.
module trig_rec_fifo #(
   parameter int DEPTH_LOG2 = 3,
   parameter int WIDTH      = 55
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic [DEPTH_LOG2:0]   count
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   ZERO_CNT = {(DEPTH_LOG2+1){1'b0}};
   localparam logic [DEPTH_LOG2:0]   ONE_CNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] ONE_PTR  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]      mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   count_r;
   logic                  do_wr_s;
   logic                  do_rd_s;

   assign do_wr_s = wr_en && (count_r != FULL_CNT);
   assign do_rd_s = rd_en && (count_r != ZERO_CNT);
   assign rd_data = mem_r[rd_ptr_r];
   assign count   = count_r;

   // Storage array write port
   always_ff @(posedge clk) begin
      if (do_wr_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r <= {DEPTH_LOG2{1'b0}};
         count_r  <= ZERO_CNT;
      end else begin
         if (do_wr_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_PTR;
         end
         if (do_rd_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_PTR;
         end
         case ({do_wr_s, do_rd_s})
            2'b10:   count_r <= count_r + ONE_CNT;
            2'b01:   count_r <= count_r - ONE_CNT;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/trig_stream.sv
// Captures trigger/time records on ready and streams each as 16-bit words on a valid/ack port.
// Define TRIG_STREAM_TRAILER_EN to append a fifth XOR-check word to every record.
module trig_stream
   import trig_stream_pkg::*;
#(
   parameter int         DEPTH_LOG2 = 3,
   parameter logic [4:0] CHAN_ID    = 5'd0,
   parameter logic [3:0] TAG        = TAG_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ready,
   input  logic [TRIG_W-1:0]     trignum,
   input  logic [TIME_W-1:0]     timenum,
   output logic [WORD_W-1:0]     out_data,
   output logic                  out_valid,
   input  logic                  out_ack,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic [15:0]           lost_cnt,
   output logic                  busy
);
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] ZERO_CNT = {(DEPTH_LOG2+1){1'b0}};
   localparam logic [DEPTH_LOG2:0] ONE_CNT  = {{DEPTH_LOG2{1'b0}}, 1'b1};

   state_t                state_r;
   state_t                state_next_s;
   logic [REC_W-1:0]      hold_r;
   logic [REC_W-1:0]      hold_next_s;
   logic [REC_W-1:0]      head_s;
   logic                  ovf_pend_r;
   logic [15:0]           lost_cnt_r;
   logic [WORD_W-1:0]     out_data_r;
   logic [WORD_W-1:0]     out_data_next_s;
   logic                  out_valid_r;
   logic                  out_valid_next_s;
   logic                  busy_r;
   logic                  full_s;
   logic                  push_s;
   logic                  drop_s;
   logic                  pop_s;
   logic                  fire_s;
   logic [DEPTH_LOG2:0]   count_s;
   logic [DEPTH_LOG2:0]   count_next_s;
   logic [4*WORD_W-1:0]   words_s;

   // Full is judged on the registered count, so a push coinciding with LOAD at full still drops
   assign full_s = (count_s == FULL_CNT);
   assign push_s = ready & ~full_s;
   assign drop_s = ready & full_s;
   assign pop_s  = (state_r == ST_LOAD);
   assign fire_s = out_valid_r & out_ack;

   assign out_data   = out_data_r;
   assign out_valid  = out_valid_r;
   assign fifo_count = count_s;
   assign lost_cnt   = lost_cnt_r;
   assign busy       = busy_r;

   trig_rec_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (REC_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (push_s),
      .wr_data ({ovf_pend_r, trignum, timenum}),
      .rd_en   (pop_s),
      .rd_data (head_s),
      .count   (count_s)
   );

   // Serialiser next-state
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (count_s != ZERO_CNT) begin
               state_next_s = ST_LOAD;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LOAD: state_next_s = ST_W0;
         ST_W0:   state_next_s = fire_s ? ST_W1 : ST_W0;
         ST_W1:   state_next_s = fire_s ? ST_W2 : ST_W1;
         ST_W2:   state_next_s = fire_s ? ST_W3 : ST_W2;
`ifdef TRIG_STREAM_TRAILER_EN
         ST_W3:   state_next_s = fire_s ? ST_TRL : ST_W3;
         ST_TRL:  state_next_s = fire_s ? ST_IDLE : ST_TRL;
`else
         ST_W3:   state_next_s = fire_s ? ST_IDLE : ST_W3;
`endif
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Next output word, taken from the record the FSM will hold after this edge
   always_comb begin
      hold_next_s      = pop_s ? head_s : hold_r;
      words_s          = rec_words(hold_next_s, TAG, CHAN_ID);
      out_data_next_s  = {WORD_W{1'b0}};
      out_valid_next_s = 1'b1;
      case (state_next_s)
         ST_W0: out_data_next_s = words_s[63:48];
         ST_W1: out_data_next_s = words_s[47:32];
         ST_W2: out_data_next_s = words_s[31:16];
         ST_W3: out_data_next_s = words_s[15:0];
`ifdef TRIG_STREAM_TRAILER_EN
         ST_TRL: out_data_next_s = words_s[63:48] ^ words_s[47:32] ^
                                   words_s[31:16] ^ words_s[15:0];
`endif
         default: begin
            out_data_next_s  = {WORD_W{1'b0}};
            out_valid_next_s = 1'b0;
         end
      endcase
   end

   // Occupancy after this edge, used for the registered busy flag
   always_comb begin
      count_next_s = count_s;
      if (push_s && !pop_s) begin
         count_next_s = count_s + ONE_CNT;
      end else if (pop_s && !push_s) begin
         count_next_s = count_s - ONE_CNT;
      end else begin
         count_next_s = count_s;
      end
   end

   // State, holding register, overflow tracking and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         hold_r      <= {REC_W{1'b0}};
         ovf_pend_r  <= 1'b0;
         lost_cnt_r  <= 16'h0000;
         out_data_r  <= {WORD_W{1'b0}};
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         hold_r      <= hold_next_s;
         out_data_r  <= out_data_next_s;
         out_valid_r <= out_valid_next_s;
         busy_r      <= (count_next_s != ZERO_CNT) || (state_next_s != ST_IDLE);
         if (push_s) begin
            ovf_pend_r <= 1'b0;
         end else if (drop_s) begin
            ovf_pend_r <= 1'b1;
         end
         if (drop_s && (lost_cnt_r != 16'hFFFF)) begin
            lost_cnt_r <= lost_cnt_r + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_trig_stream.sv
// Randomised and directed bench for trig_stream against a queue-based record/word model.
module tb_trig_stream;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ready;
   logic [17:0] trignum;
   logic [35:0] timenum;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ack;
   logic [3:0]  fifo_count;
   logic [15:0] lost_cnt;
   logic        busy;

   always #3 clk = ~clk;

   trig_stream dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .ready      (ready),
      .trignum    (trignum),
      .timenum    (timenum),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ack    (out_ack),
      .fifo_count (fifo_count),
      .lost_cnt   (lost_cnt),
      .busy       (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: stored records, words still owed for the record in flight, and a coarse phase
   // (0 = nothing in flight, 1 = fetching a record, 2 = presenting words).
   logic [54:0] mq[$];
   logic [15:0] mw[$];
   int          ph;
   logic [15:0] m_lost;
   logic        m_ovf;

   bit          logging = 1'b0;
   logic        obs_valid[$];
   logic [15:0] obs_data[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mw.delete();
      ph     = 0;
      m_lost = 16'd0;
      m_ovf  = 1'b0;
   endtask

   task automatic expand(input logic [54:0] rec);
      longint unsigned tn, tm, ovf, w0, w1, w2, w3, trl;
      tn  = 64'(rec[53:36]);
      tm  = 64'(rec[35:0]);
      ovf = 64'(rec[54]);
      w0  = (64'hF << 12) | (tn >> 6);
      w1  = ((tn % 64'd64) << 10) | (tm >> 26);
      w2  = (tm >> 10) % 64'd65536;
      w3  = ((tm % 64'd1024) << 6) | (ovf << 5) | 64'd0;
      mw.push_back(w0[15:0]);
      mw.push_back(w1[15:0]);
      mw.push_back(w2[15:0]);
      mw.push_back(w3[15:0]);
`ifdef TRIG_STREAM_TRAILER_EN
      trl = w0 ^ w1 ^ w2 ^ w3;
      mw.push_back(trl[15:0]);
`else
      trl = 64'd0;
`endif
   endtask

   task automatic model_edge(input bit rdy, input logic [17:0] tn, input logic [35:0] tm,
                             input bit ack);
      int sz0;
      bit full;
      sz0  = mq.size();
      full = (sz0 == DEPTH);
      if (ph == 1) begin
         expand(mq.pop_front());
         ph = 2;
      end else if (ph == 2) begin
         if (ack) begin
            void'(mw.pop_front());
            if (mw.size() == 0) ph = 0;
         end
      end else if (sz0 > 0) begin
         ph = 1;
      end
      if (rdy) begin
         if (full) begin
            if (m_lost != 16'hFFFF) m_lost = m_lost + 16'd1;
            m_ovf = 1'b1;
         end else begin
            mq.push_back({m_ovf, tn, tm});
            m_ovf = 1'b0;
         end
      end
   endtask

   task automatic compare();
      chk("fifo_count", fifo_count, mq.size());
      chk("lost_cnt", lost_cnt, m_lost);
      chk("out_valid", out_valid, (ph == 2));
      chk("busy", busy, (mq.size() != 0) || (ph != 0));
      if (ph == 2 && mw.size() > 0) chk("out_data", out_data, mw[0]);
      if (logging) begin
         obs_valid.push_back(out_valid);
         obs_data.push_back(out_data);
      end
   endtask

   // One clock: drive at negedge, update model at posedge, check at the next negedge.
   task automatic cyc(input bit rdy, input logic [17:0] tn, input logic [35:0] tm, input bit ack);
      ready   = rdy;
      trignum = tn;
      timenum = tm;
      out_ack = ack;
      @(posedge clk);
      model_edge(rdy, tn, tm, ack);
      @(negedge clk);
      compare();
   endtask

   task automatic rcyc(input bit rdy, input bit ack);
      logic [63:0] r;
      r = {$urandom, $urandom};
      cyc(rdy, r[53:36], r[35:0], ack);
   endtask

   task automatic idle(input int n, input bit ack);
      for (int i = 0; i < n; i++) cyc(1'b0, 18'd0, 36'd0, ack);
   endtask

   task automatic start_log();
      obs_valid.delete();
      obs_data.delete();
      logging = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      ready   = 1'b0;
      trignum = 18'd0;
      timenum = 36'd0;
      out_ack = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset out_data", out_data, 16'h0000);
      chk("reset fifo_count", fifo_count, 4'd0);
      chk("reset lost_cnt", lost_cnt, 16'h0000);
      chk("reset busy", busy, 1'b0);
      reset_n = 1'b1;
      idle(2, 1'b1);

      // Single record, ack held high
      start_log();
      cyc(1'b1, 18'h2ABCD, 36'h9_1234_5678, 1'b1);
      idle(8, 1'b1);
      logging = 1'b0;
      chk("t1 no word at N+1", obs_valid[1], 1'b0);
      chk("t1 W0 valid at N+2", obs_valid[2], 1'b1);
      chk("t1 W0", obs_data[2], 16'hFAAF);
      chk("t1 W1", obs_data[3], 16'h3644);
      chk("t1 W2", obs_data[4], 16'h8D15);
      chk("t1 W3", obs_data[5], 16'h9E00);
`ifdef TRIG_STREAM_TRAILER_EN
      chk("t1 TRL", obs_data[6], 16'hDFFE);
      chk("t1 end", obs_valid[7], 1'b0);
`else
      chk("t1 end", obs_valid[6], 1'b0);
`endif

      // Backpressure during W1
      start_log();
      cyc(1'b1, 18'h2ABCD, 36'h9_1234_5678, 1'b1);
      idle(3, 1'b1);
      idle(3, 1'b0);
      idle(6, 1'b1);
      logging = 1'b0;
      for (int i = 3; i <= 6; i++) chk("t2 W1 held", {obs_valid[i], obs_data[i]}, {1'b1, 16'h3644});
      chk("t2 W2 after stall", obs_data[7], 16'h8D15);
      chk("t2 W3 after stall", obs_data[8], 16'h9E00);

      // Overflow: 11 back-to-back pulses with the consumer stalled
      for (int i = 0; i < 11; i++) rcyc(1'b1, 1'b0);
      chk("t3 fifo_count full", fifo_count, 4'd8);
      chk("t3 lost_cnt", lost_cnt, 16'd2);
      idle(70, 1'b1);
      start_log();
      rcyc(1'b1, 1'b1);
      idle(8, 1'b1);
      chk("t3 ovf flagged", obs_data[5][5], 1'b1);
      start_log();
      rcyc(1'b1, 1'b1);
      idle(8, 1'b1);
      logging = 1'b0;
      chk("t3 ovf cleared", obs_data[5][5], 1'b0);

      // Push on the LOAD cycle with one record held
      rcyc(1'b1, 1'b1);
      idle(1, 1'b1);
      rcyc(1'b1, 1'b1);
      chk("t4 fifo_count", fifo_count, 4'd1);
      chk("t4 lost_cnt", lost_cnt, 16'd2);
      idle(20, 1'b1);

      // Reset while a record is mid-stream
      rcyc(1'b1, 1'b1);
      rcyc(1'b1, 1'b1);
      idle(3, 1'b1);
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("t5 out_valid", out_valid, 1'b0);
      chk("t5 fifo_count", fifo_count, 4'd0);
      chk("t5 lost_cnt", lost_cnt, 16'h0000);
      chk("t5 busy", busy, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      start_log();
      cyc(1'b1, 18'h2ABCD, 36'h9_1234_5678, 1'b1);
      idle(8, 1'b1);
      logging = 1'b0;
      chk("t5 clean W0", {obs_valid[2], obs_data[2]}, {1'b1, 16'hFAAF});
      chk("t5 gap before", obs_valid[1], 1'b0);

      // Random traffic in bursts with varying backpressure
      for (int b = 0; b < 30; b++) begin
         int rp, ap;
         rp = $urandom_range(5, 60);
         ap = $urandom_range(10, 100);
         for (int i = 0; i < 100; i++)
            rcyc($urandom_range(0, 99) < rp, $urandom_range(0, 99) < ap);
      end
      idle(80, 1'b1);

      // Saturating drop counter
      for (int i = 0; i < 65545; i++) rcyc(1'b1, 1'b0);
      chk("t6 lost_cnt saturated", lost_cnt, 16'hFFFF);
      idle(80, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
